pipeline_hazard_controller: RTL and testbench

Stall/flush sequencer for the 5-stage pipeline: replaces the tied-high PCWrite, DecodeWrite and controlMuxSignal in top_level with driven signals. The pipeline has no forwarding unit and resolves branches/jumps in decode, so this block detects RAW hazards against the EX and MEM stages. It freezes PC and IF/ID, injects control bubbles into ID/EX, and flushes IF/ID on a taken redirect. It also keeps saturating stall/flush statistics.

---
 rtl/pipeline_hazard_controller.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// There is no forwarding, so a decode instruction that reads a register still
// being produced in EX or MEM is held in decode until the writer reaches WB.
// An EX dependency costs two stall cycles and a MEM dependency costs one.
// A taken branch, j, jal or jr resolved in decode squashes the fall-through
// fetch that is already sitting in IF/ID.
// Stall and flush counts are kept in saturating statistics counters.
module pipeline_hazard_controller #(
  parameter int STAT_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [4:0]        RsDecode,
  input  logic [4:0]        RtDecode,
  input  logic              UseRs,
  input  logic              UseRt,
  input  logic              Redirect,
  input  logic [4:0]        RdExecute,
  input  logic              RegWriteExecute,
  input  logic [4:0]        RdMemory,
  input  logic              RegWriteMemory,
  input  logic              ClearStats,
  output logic              PCWrite,
  output logic              DecodeWrite,
  output logic              ControlMuxSignal,
  output logic              FlushDecode,
  output logic              State,
  output logic [STAT_W-1:0] StallCycles,
  output logic [STAT_W-1:0] FlushCount
);

  // RUN: normal issue, or a re-evaluated MEM-stage stall.
  // STALL: second cycle of an EX-stage stall; inputs are ignored here.
  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stateT;

  stateT stateQ, stateNext;
  logic  stallCnt, stallCntNext;
  logic  hazEx, hazMem;
  logic  stallActive, flushActive;

  // Register 0 never carries a dependency. A WB-stage writer is not checked
  // because the register file writes before decode reads in the same cycle.
  always_comb begin
    hazEx  = RegWriteExecute && (RdExecute != 5'd0) &&
             ((UseRs && (RsDecode == RdExecute)) ||
              (UseRt && (RtDecode == RdExecute)));
    hazMem = RegWriteMemory && (RdMemory != 5'd0) &&
             ((UseRs && (RsDecode == RdMemory)) ||
              (UseRt && (RtDecode == RdMemory)));
  end

  // State and stall countdown register; reset aborts any stall in progress.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stateQ   <= RUN;
      stallCnt <= 1'b0;
    end else begin
      stateQ   <= stateNext;
      stallCnt <= stallCntNext;
    end
  end

  // Next-state and stall/flush decision. A redirect is only honoured with no
  // hazard pending: branch operands are stale while stalled, and the frozen
  // decode instruction re-presents the redirect once the stall clears.
  always_comb begin
    stateNext    = stateQ;
    stallCntNext = stallCnt;
    stallActive  = 1'b0;
    flushActive  = 1'b0;
    case (stateQ)
      RUN: begin
        if (hazEx) begin
          stallActive  = 1'b1;
          stallCntNext = 1'b1;
          stateNext    = STALL;
        end else if (hazMem) begin
          stallActive = 1'b1;
        end else begin
          flushActive = Redirect;
        end
      end
      STALL: begin
        stallActive  = 1'b1;
        stallCntNext = stallCnt - 1'b1;
        if (stallCnt) begin
          stateNext = RUN;
        end
      end
      default: begin
        stateNext    = RUN;
        stallCntNext = 1'b0;
      end
    endcase
  end

  // Pipeline control outputs; while Reset is high the pipeline free-runs.
  // PC keeps loading during a flush so it picks up the redirect target.
  always_comb begin
    PCWrite          = Reset || !stallActive;
    DecodeWrite      = Reset || !stallActive;
    ControlMuxSignal = Reset || !stallActive;
    FlushDecode      = !Reset && flushActive;
    State            = stateQ;
  end

  // Saturating count of cycles with stall outputs active; clear wins.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCycles <= '0;
    end else if (ClearStats) begin
      StallCycles <= '0;
    end else if (stallActive && (StallCycles != '1)) begin
      StallCycles <= StallCycles + 1'b1;
    end
  end

  // Saturating count of issued flushes; clear wins.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FlushCount <= '0;
    end else if (ClearStats) begin
      FlushCount <= '0;
    end else if (flushActive && (FlushCount != '1)) begin
      FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with hand-computed expectations.
module tb_pipeline_hazard_controller;

  localparam int STAT_W = 16;

  logic              Clk;
  logic              Reset;
  logic [4:0]        RsDecode, RtDecode, RdExecute, RdMemory;
  logic              UseRs, UseRt, Redirect;
  logic              RegWriteExecute, RegWriteMemory, ClearStats;
  logic              PCWrite, DecodeWrite, ControlMuxSignal, FlushDecode, State;
  logic [STAT_W-1:0] StallCycles, FlushCount;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_controller #(.STAT_W(STAT_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .RsDecode(RsDecode), .RtDecode(RtDecode), .UseRs(UseRs), .UseRt(UseRt),
    .Redirect(Redirect),
    .RdExecute(RdExecute), .RegWriteExecute(RegWriteExecute),
    .RdMemory(RdMemory), .RegWriteMemory(RegWriteMemory),
    .ClearStats(ClearStats),
    .PCWrite(PCWrite), .DecodeWrite(DecodeWrite),
    .ControlMuxSignal(ControlMuxSignal), .FlushDecode(FlushDecode),
    .State(State), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  // clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // PCWrite, DecodeWrite, ControlMuxSignal, FlushDecode, State packed
  task automatic chkOut(input string tag, input logic [4:0] exp);
    chk(tag, {PCWrite, DecodeWrite, ControlMuxSignal, FlushDecode, State}, {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idleInputs();
    RsDecode = 5'd0; RtDecode = 5'd0; UseRs = 1'b0; UseRt = 1'b0;
    Redirect = 1'b0; RdExecute = 5'd0; RegWriteExecute = 1'b0;
    RdMemory = 5'd0; RegWriteMemory = 1'b0; ClearStats = 1'b0;
  endtask

  initial begin
    idleInputs();
    // Reset with an EX hazard presented: run outputs forced
    Reset = 1'b1;
    UseRs = 1'b1; RsDecode = 5'd5; RdExecute = 5'd5; RegWriteExecute = 1'b1;
    #2;
    chkOut("reset_outputs", 5'b11100);
    chk("reset_stall_cycles", StallCycles, 0);
    chk("reset_flush_count", FlushCount, 0);
    tick();
    tick();
    chkOut("reset_held", 5'b11100);

    // EX dependency: 2-cycle stall
    Reset = 1'b0;
    #1;
    chkOut("ex_stall_c1", 5'b00000);
    tick();
    // add moves to MEM, bubble in EX
    RdExecute = 5'd0; RegWriteExecute = 1'b0; RdMemory = 5'd5; RegWriteMemory = 1'b1;
    #1;
    chkOut("ex_stall_c2", 5'b00001);
    tick();
    idleInputs(); UseRs = 1'b1; RsDecode = 5'd5;
    #1;
    chkOut("ex_stall_done", 5'b11100);
    chk("ex_stall_count", StallCycles, 2);

    // MEM-only dependency: 1-cycle stall, State stays RUN
    idleInputs(); UseRt = 1'b1; RtDecode = 5'd7; RdMemory = 5'd7; RegWriteMemory = 1'b1;
    #1;
    chkOut("mem_stall", 5'b00000);
    tick();
    chk("mem_state_after", State, 0);
    RdMemory = 5'd0; RegWriteMemory = 1'b0;
    #1;
    chkOut("mem_stall_done", 5'b11100);
    chk("mem_stall_count", StallCycles, 3);

    // Writer to $0 in EX and MEM: never a hazard
    idleInputs(); UseRs = 1'b1; UseRt = 1'b1;
    RegWriteExecute = 1'b1; RegWriteMemory = 1'b1;
    #1;
    chkOut("zero_reg_no_stall", 5'b11100);
    // Matching register but no write: no hazard
    RsDecode = 5'd3; RdExecute = 5'd3; RegWriteExecute = 1'b0; RegWriteMemory = 1'b0;
    #1;
    chkOut("no_write_no_stall", 5'b11100);
    // Matching rt but UseRt clear: no hazard
    idleInputs(); RtDecode = 5'd4; RdExecute = 5'd4; RegWriteExecute = 1'b1;
    #1;
    chkOut("unused_rt_no_stall", 5'b11100);
    tick();
    chk("no_stall_count", StallCycles, 3);

    // Redirect, no hazard: flush with PC still loading; back-to-back flushes
    idleInputs(); Redirect = 1'b1;
    #1;
    chkOut("flush_1", 5'b11110);
    tick();
    chk("flush_count_1", FlushCount, 1);
    chkOut("flush_2", 5'b11110);
    tick();
    chk("flush_count_2", FlushCount, 2);

    // Redirect with EX hazard: deferred until stall elapses
    UseRs = 1'b1; RsDecode = 5'd6; RdExecute = 5'd6; RegWriteExecute = 1'b1;
    #1;
    chkOut("redir_haz_c1", 5'b00000);
    tick();
    chkOut("redir_haz_c2", 5'b00001);
    tick();
    RdExecute = 5'd0; RegWriteExecute = 1'b0;
    #1;
    chkOut("redir_after_stall", 5'b11110);
    tick();
    chk("redir_flush_count", FlushCount, 3);
    chk("redir_stall_count", StallCycles, 5);

    // Reset during STALL cycle aborts immediately
    idleInputs(); UseRs = 1'b1; RsDecode = 5'd8; RdExecute = 5'd8; RegWriteExecute = 1'b1;
    tick();
    chk("pre_reset_state", State, 1);
    Reset = 1'b1;
    #1;
    chkOut("reset_mid_stall", 5'b11100);
    chk("reset_mid_stall_count", StallCycles, 0);
    idleInputs();
    #1;
    Reset = 1'b0;
    #1;
    chkOut("post_reset_run", 5'b11100);
    tick();
    chkOut("post_reset_cycle2", 5'b11100);

    // Saturation: continuous MEM hazard for more than 2^16 cycles
    UseRs = 1'b1; RsDecode = 5'd9; RdMemory = 5'd9; RegWriteMemory = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    chk("stall_saturated", StallCycles, 16'hFFFF);
    tick();
    chk("stall_sat_hold", StallCycles, 16'hFFFF);
    ClearStats = 1'b1;
    tick();
    chk("clear_priority", StallCycles, 0);
    ClearStats = 1'b0;
    tick();
    chk("count_after_clear", StallCycles, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
